// File: rtl/id_ex_stage_pkg.sv
// rtl/id_ex_stage_pkg.sv - shared widths, control field layout and ALU encodings for the ID/EX stage
package id_ex_stage_pkg;

    localparam int WORD_LEN = 32;
    localparam int RA_LEN   = 5;

    // Control bit positions measured from the top of the alu_ctrl field.
    localparam int CTRL_EXT_ZERO  = 0;
    localparam int CTRL_REG_DST   = 1;
    localparam int CTRL_ALU_SRC   = 2;
    localparam int CTRL_MEM_WRITE = 3;
    localparam int CTRL_MEM_TO_REG = 4;
    localparam int CTRL_REG_WRITE = 5;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_e;

    function automatic logic [WORD_LEN-1:0] extend_imm(input logic [15:0] imm, input logic zero_ext);
        extend_imm = zero_ext ? {16'b0, imm} : {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/id_ex_stage_operand_bypass.sv
// rtl/id_ex_stage_operand_bypass.sv - regfile write-port compare and operand select
module operand_bypass
    import id_ex_stage_pkg::*;
(
    input  logic                wb_we,
    input  logic [RA_LEN-1:0]   wb_wa,
    input  logic [WORD_LEN-1:0] wb_wd,
    input  logic [RA_LEN-1:0]   ra,
    input  logic [WORD_LEN-1:0] rdata,
    output logic [WORD_LEN-1:0] data
);

    logic hit;

    // r0 is hardwired, so a write aimed at it must never leak into an operand.
    assign hit  = wb_we && (wb_wa == ra) && (ra != '0);
    assign data = hit ? wb_wd : rdata;

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with write bypass, load-use hazard and bubble counting
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int ALUC_W = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [RA_LEN-1:0]     id_rs,
    input  logic [RA_LEN-1:0]     id_rt,
    input  logic [RA_LEN-1:0]     id_rd,
    input  logic [WORD_LEN-1:0]   id_rd1,
    input  logic [WORD_LEN-1:0]   id_rd2,
    input  logic [15:0]           id_imm,
    input  logic [6+ALUC_W-1:0]   id_ctrl,
    input  logic                  wb_we,
    input  logic [RA_LEN-1:0]     wb_wa,
    input  logic [WORD_LEN-1:0]   wb_wd,
    output logic                  ex_valid,
    output logic [RA_LEN-1:0]     ex_rs,
    output logic [RA_LEN-1:0]     ex_rt,
    output logic [RA_LEN-1:0]     ex_rd,
    output logic [WORD_LEN-1:0]   ex_a,
    output logic [WORD_LEN-1:0]   ex_b,
    output logic [WORD_LEN-1:0]   ex_imm,
    output logic [6+ALUC_W-1:0]   ex_ctrl,
    output logic                  hazard,
    output logic [CNT_W-1:0]      bubble_cnt
);

    localparam int BIT_REG_WRITE  = ALUC_W + CTRL_REG_WRITE;
    localparam int BIT_MEM_TO_REG = ALUC_W + CTRL_MEM_TO_REG;
    localparam int BIT_EXT_ZERO   = ALUC_W + CTRL_EXT_ZERO;

    logic [RA_LEN-1:0]   ra_a, ra_b;
    logic [WORD_LEN-1:0] src_a, src_b;
    logic [WORD_LEN-1:0] byp_a, byp_b;
    logic                bubble;

    // While held, the muxes look at the EX copy so a writeback refreshes it in place.
    assign ra_a  = stall ? ex_rs : id_rs;
    assign ra_b  = stall ? ex_rt : id_rt;
    assign src_a = stall ? ex_a  : id_rd1;
    assign src_b = stall ? ex_b  : id_rd2;

    operand_bypass u_byp_a (
        .wb_we (wb_we),
        .wb_wa (wb_wa),
        .wb_wd (wb_wd),
        .ra    (ra_a),
        .rdata (src_a),
        .data  (byp_a)
    );

    operand_bypass u_byp_b (
        .wb_we (wb_we),
        .wb_wa (wb_wa),
        .wb_wd (wb_wd),
        .ra    (ra_b),
        .rdata (src_b),
        .data  (byp_b)
    );

    assign hazard = ex_valid && ex_ctrl[BIT_MEM_TO_REG] && ex_ctrl[BIT_REG_WRITE] &&
                    (ex_rt != '0) && id_valid && ((id_rs == ex_rt) || (id_rt == ex_rt));

    assign bubble = flush || (!stall && hazard);

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid   <= 1'b0;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_rd      <= '0;
            ex_a       <= '0;
            ex_b       <= '0;
            ex_imm     <= '0;
            ex_ctrl    <= '0;
            bubble_cnt <= '0;
        end else if (bubble) begin
            ex_valid <= 1'b0;
            ex_rs    <= '0;
            ex_rt    <= '0;
            ex_rd    <= '0;
            ex_a     <= '0;
            ex_b     <= '0;
            ex_imm   <= '0;
            ex_ctrl  <= '0;
            if (bubble_cnt != '1)
                bubble_cnt <= bubble_cnt + CNT_W'(1);
        end else if (stall) begin
            ex_a <= byp_a;
            ex_b <= byp_b;
        end else begin
            ex_valid <= id_valid;
            ex_rs    <= id_rs;
            ex_rt    <= id_rt;
            ex_rd    <= id_rd;
            ex_a     <= byp_a;
            ex_b     <= byp_b;
            ex_imm   <= extend_imm(id_imm, id_ctrl[BIT_EXT_ZERO]);
            ex_ctrl  <= id_valid ? id_ctrl : '0;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed table-driven bench for id_ex_stage
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    localparam int CNT_W  = 4;
    localparam int ALUC_W = 3;

    localparam logic [8:0] C_ADD  = 9'b100010010;
    localparam logic [8:0] C_LW   = 9'b110100010;
    localparam logic [8:0] C_ADDI = 9'b100100010;
    localparam logic [8:0] C_ORI  = 9'b100101001;

    logic        clk = 1'b0;
    logic        reset, stall, flush, id_valid;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rd1, id_rd2;
    logic [15:0] id_imm;
    logic [8:0]  id_ctrl;
    logic        wb_we;
    logic [4:0]  wb_wa;
    logic [31:0] wb_wd;
    logic        ex_valid;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [31:0] ex_a, ex_b, ex_imm;
    logic [8:0]  ex_ctrl;
    logic        hazard;
    logic [CNT_W-1:0] bubble_cnt;

    int total = 0;
    int bad = 0;

    id_ex_stage #(.CNT_W(CNT_W), .ALUC_W(ALUC_W)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_rd1(id_rd1), .id_rd2(id_rd2),
        .id_imm(id_imm), .id_ctrl(id_ctrl), .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
        .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_a(ex_a),
        .ex_b(ex_b), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl), .hazard(hazard), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [4:0]  rs, rt, rd;
        logic [31:0] rd1, rd2;
        logic [15:0] imm;
        logic [8:0]  ctrl;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        e_valid;
        logic [31:0] e_a, e_b, e_imm;
        logic [8:0]  e_ctrl;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [31:0] d1, input logic [31:0] d2, input logic [15:0] imm,
                          input logic [8:0] c);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
        id_rd1 = d1; id_rd2 = d2; id_imm = imm; id_ctrl = c;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1, 1, 2, 3, 32'h11111111, 32'h22222222, 16'h0004, C_ADD, 0, 0, 0,
                    1, 32'h11111111, 32'h22222222, 32'h00000004, C_ADD};
        vecs[1] = '{1, 5, 6, 3, 32'h0, 32'h00000066, 16'h0000, C_ADD, 1, 5, 32'hA5A5A5A5,
                    1, 32'hA5A5A5A5, 32'h00000066, 32'h0, C_ADD};
        vecs[2] = '{1, 0, 6, 3, 32'h0, 32'h00000066, 16'h0000, C_ADD, 1, 0, 32'hA5A5A5A5,
                    1, 32'h0, 32'h00000066, 32'h0, C_ADD};
        vecs[3] = '{1, 7, 7, 8, 32'h1, 32'h2, 16'h0001, C_ADD, 1, 7, 32'hDEADBEEF,
                    1, 32'hDEADBEEF, 32'hDEADBEEF, 32'h00000001, C_ADD};
        vecs[4] = '{1, 7, 9, 8, 32'h3, 32'h4, 16'h0001, C_ADD, 0, 7, 32'hDEADBEEF,
                    1, 32'h3, 32'h4, 32'h00000001, C_ADD};
        vecs[5] = '{1, 2, 4, 0, 32'h5, 32'h6, 16'h8000, C_ADDI, 0, 0, 0,
                    1, 32'h5, 32'h6, 32'hFFFF8000, C_ADDI};
        vecs[6] = '{1, 2, 4, 0, 32'h5, 32'h6, 16'h8000, C_ORI, 0, 0, 0,
                    1, 32'h5, 32'h6, 32'h00008000, C_ORI};
        vecs[7] = '{0, 1, 2, 3, 32'h77, 32'h88, 16'h7FFF, C_ADD, 0, 0, 0,
                    0, 32'h77, 32'h88, 32'h00007FFF, 9'h0};

        reset = 1'b1; stall = 0; flush = 0; wb_we = 0; wb_wa = 0; wb_wd = 0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        reset = 1'b0;
        chk("rst_valid", {31'b0, ex_valid}, 32'h0);
        chk("rst_ctrl", {23'b0, ex_ctrl}, 32'h0);
        chk("rst_cnt", {28'b0, bubble_cnt}, 32'h0);

        // single-cycle loads with bypass and immediate extension
        for (int i = 0; i < 8; i++) begin
            set_id(vecs[i].valid, vecs[i].rs, vecs[i].rt, vecs[i].rd,
                   vecs[i].rd1, vecs[i].rd2, vecs[i].imm, vecs[i].ctrl);
            wb_we = vecs[i].we; wb_wa = vecs[i].wa; wb_wd = vecs[i].wd;
            #1;
            chk($sformatf("v%0d_hazard", i), {31'b0, hazard}, 32'h0);
            tick();
            chk($sformatf("v%0d_valid", i), {31'b0, ex_valid}, {31'b0, vecs[i].e_valid});
            chk($sformatf("v%0d_a", i), ex_a, vecs[i].e_a);
            chk($sformatf("v%0d_b", i), ex_b, vecs[i].e_b);
            chk($sformatf("v%0d_imm", i), ex_imm, vecs[i].e_imm);
            chk($sformatf("v%0d_ctrl", i), {23'b0, ex_ctrl}, {23'b0, vecs[i].e_ctrl});
            chk($sformatf("v%0d_cnt", i), {28'b0, bubble_cnt}, 32'h0);
        end
        wb_we = 0;

        // reset held two cycles mid-stream
        set_id(1, 1, 3, 2, 32'h9, 32'h9, 16'h1234, C_LW);
        tick();
        do_reset();
        chk("mid_rst_valid", {31'b0, ex_valid}, 32'h0);
        chk("mid_rst_a", ex_a, 32'h0);
        chk("mid_rst_imm", ex_imm, 32'h0);
        chk("mid_rst_rt", {27'b0, ex_rt}, 32'h0);

        // load-use hazard
        set_id(1, 1, 3, 0, 32'h100, 32'h0, 16'h0, C_LW);
        tick();
        set_id(1, 3, 4, 5, 32'h0, 32'h0, 16'h0, C_ADD);
        #1;
        chk("lu_hazard", {31'b0, hazard}, 32'h1);
        tick();
        chk("lu_valid", {31'b0, ex_valid}, 32'h0);
        chk("lu_cnt", {28'b0, bubble_cnt}, 32'h1);
        chk("lu_hazard_clr", {31'b0, hazard}, 32'h0);
        tick();
        chk("lu_reload", {27'b0, ex_rd}, 32'h5);

        // stall hold with writeback refresh of ex_b
        set_id(1, 2, 3, 4, 32'h1, 32'h2, 16'h0010, C_ADD);
        tick();
        stall = 1;
        set_id(1, 9, 10, 11, 32'hBAD, 32'hBAD, 16'hFFFF, C_ORI);
        tick();
        wb_we = 1; wb_wa = 3; wb_wd = 32'h3C3C3C3C;
        tick();
        wb_we = 0;
        tick();
        chk("st_b", ex_b, 32'h3C3C3C3C);
        chk("st_a", ex_a, 32'h1);
        chk("st_rd", {27'b0, ex_rd}, 32'h4);
        chk("st_imm", ex_imm, 32'h10);
        chk("st_ctrl", {23'b0, ex_ctrl}, {23'b0, C_ADD});
        chk("st_cnt", {28'b0, bubble_cnt}, 32'h1);
        stall = 0;
        tick();
        chk("st_release_rd", {27'b0, ex_rd}, 32'hB);
        chk("st_release_imm", ex_imm, 32'h0000FFFF);

        // flush coinciding with a load-use hazard: one bubble only
        set_id(1, 1, 3, 0, 32'h0, 32'h0, 16'h0, C_LW);
        tick();
        set_id(1, 3, 3, 6, 32'h0, 32'h0, 16'h0, C_ADD);
        flush = 1;
        #1;
        chk("fh_hazard", {31'b0, hazard}, 32'h1);
        tick();
        flush = 0;
        chk("fh_valid", {31'b0, ex_valid}, 32'h0);
        chk("fh_cnt", {28'b0, bubble_cnt}, 32'h2);
        tick();
        chk("fh_cnt_once", {28'b0, bubble_cnt}, 32'h2);
        chk("fh_reload", {27'b0, ex_rd}, 32'h6);

        // saturation of the bubble counter
        do_reset();
        flush = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 13) chk("sat_14", {28'b0, bubble_cnt}, 32'hE);
        end
        flush = 0;
        chk("sat_final", {28'b0, bubble_cnt}, 32'hF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
